// File: rtl/ucsbece154a_controller_mc.sv
// Multicycle RV32I-subset controller: Moore FSM sequencing a shared-memory
// datapath, plus combinational immediate-format and ALU-operation decoders.
//
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   op_i, funct3_i, funct7b5_i           instruction fields from IR
//   zero_i                               ALU zero flag (branch decision)
//   PCWrite_o, AdrSrc_o, MemWrite_o      PC enable, address mux, mem write
//   IRWrite_o, RegWrite_o                IR/OldPC enable, regfile write
//   ResultSrc_o, ALUSrcA_o, ALUSrcB_o    datapath mux selects
//   ALUControl_o, ImmSrc_o               ALU op and immediate format
//   illegal_o                            unsupported opcode seen in DECODE
//   state_o                              current state (debug)
module ucsbece154a_controller_mc (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       RegWrite_o,
    output logic [2:0] ALUControl_o,
    output logic [2:0] ImmSrc_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch/jump target lands in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op_i)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_LUI:       state_nxt = S_LUI;
                    default: begin
                        state_nxt = S_FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                // Return address PC+4 computed from OldPC; target from ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        ALUControl_o = 3'b000;
        case (alu_op)
            2'b00: ALUControl_o = 3'b000;
            2'b01: ALUControl_o = 3'b001;
            2'b10: begin
                case (funct3_i)
                    // op_i[5] separates R-type sub from I-type addi
                    3'b000:  ALUControl_o = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl_o = 3'b101;
                    3'b110:  ALUControl_o = 3'b011;
                    3'b111:  ALUControl_o = 3'b010;
                    default: ALUControl_o = 3'b000;
                endcase
            end
            default: ALUControl_o = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc_o = 3'b000;
        case (op_i)
            OP_SW:   ImmSrc_o = 3'b001;
            OP_BEQ:  ImmSrc_o = 3'b010;
            OP_JAL:  ImmSrc_o = 3'b011;
            OP_LUI:  ImmSrc_o = 3'b100;
            default: ImmSrc_o = 3'b000;
        endcase
    end

    // Write enables are held off while reset is asserted
    assign PCWrite_o   = reset_n & (pc_update | (branch & zero_i));
    assign IRWrite_o   = reset_n & ir_write;
    assign RegWrite_o  = reset_n & reg_write;
    assign MemWrite_o  = reset_n & mem_write;
    assign illegal_o   = reset_n & illegal;
    assign AdrSrc_o    = adr_src;
    assign ResultSrc_o = result_src;
    assign ALUSrcA_o   = alu_src_a;
    assign ALUSrcB_o   = alu_src_b;
    assign state_o     = state;

endmodule

// File: doc/ucsbece154a_controller_mc.md
# ucsbece154a_controller_mc

Multicycle RV32I-subset controller: a Moore FSM that sequences a shared-memory multicycle datapath (PC, IR, OldPC, Data, ALUOut registers; one ALU; one memory) through fetch, decode, execute, memory and writeback steps. It issues per-cycle register-enable, mux-select and ALU controls, and decodes immediate format and ALU operation from the instruction fields. It sits beside the multicycle datapath at the top of the processor, replacing the single-cycle controller.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op_i  in  7  instruction opcode (IR[6:0])
- funct3_i  in  3  IR[14:12]
- funct7b5_i  in  1  IR[30]
- zero_i  in  1  ALU zero flag
- PCWrite_o  out  1  PC register enable
- AdrSrc_o  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite_o  out  1  memory write enable
- IRWrite_o  out  1  IR/OldPC enable
- ResultSrc_o  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
- ALUSrcA_o  out  2  00 = PC, 01 = OldPC, 10 = rs1 (A)
- ALUSrcB_o  out  2  00 = rs2 (WriteData), 01 = ImmExt, 10 = constant 4
- RegWrite_o  out  1  register file write enable
- ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal_o  out  1  one-cycle pulse: unsupported opcode seen in DECODE
- state_o  out  4  current state encoding (debug)

## Operation
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111.
- States and encodings:
  - FETCH 0: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is DECODE.
  - DECODE 1: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut). Next state: lw/sw go to MEMADR, R-type to EXECUTER, I-ALU to EXECUTEI, beq to BEQ, jal to JAL, lui to LUI. Any other opcode returns to FETCH with illegal_o=1.
  - MEMADR 2: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: lw goes to MEMREAD, sw goes to MEMWRITE.
  - MEMREAD 3: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
  - MEMWB 4: ResultSrc=01, RegWrite=1. Next state is FETCH.
  - MEMWRITE 5: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state is FETCH.
  - EXECUTER 6: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
  - EXECUTEI 7: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
  - ALUWB 8: ResultSrc=00, RegWrite=1. Next state is FETCH.
  - BEQ 9: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state is FETCH.
  - JAL 10: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
  - LUI 11: ResultSrc=11, RegWrite=1. Next state is FETCH.
- Any control not listed for a state drives 0. Encodings 12–15 drive all outputs 0, with next state FETCH.
- PCWrite_o = PCUpdate | (Branch & zero_i).
- ImmSrc_o is combinational from op_i in every state: lw and I-ALU give 000, sw 001, beq 010, jal 011, lui 100, anything else 000.
- ALU decoder:
  - ALUOp 00 gives add; ALUOp 01 gives sub.
  - ALUOp 10 decodes funct3: 000 gives sub if (funct7b5_i & op_i[5]), else add; 010 gives slt; 110 gives or; 111 gives and; any other funct3 gives 000.
- op_i and funct fields are sampled only via the IR; IR is stable outside FETCH.

## Timing
- State register updates on the rising clk edge. All outputs except ImmSrc_o and ALUControl_o are functions of state only (Moore); PCWrite_o also depends on zero_i in BEQ.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, lui 3, illegal 2.
- reset_n low:
  - State goes to FETCH immediately (asynchronously).
  - PCWrite_o, IRWrite_o, RegWrite_o, MemWrite_o and illegal_o are forced 0.
  - Other outputs take their FETCH values.
- reset_n deassertion: the first rising edge with reset_n high is spent in FETCH with write enables live.
- Reset mid-instruction abandons it; no partial writeback occurs after reset asserts.
- illegal_o is high for exactly the DECODE cycle of the unsupported opcode.

## Test plan
- Reset: hold reset_n=0 for 3 cycles mid-MEMREAD → state_o=0 and all write enables 0 immediately; after release, IRWrite_o=1 and PCWrite_o=1 on the first cycle.
- lw (op 0000011) → state_o sequence 0,1,2,3,4; MemWrite_o=0 throughout; RegWrite_o=1 only in state 4 with ResultSrc_o=01.
- sw → states 0,1,2,5; MemWrite_o=1 and AdrSrc_o=1 only in state 5; ImmSrc_o=001.
- R-type sub (funct3 000, funct7b5 1) → states 0,1,6,8 with ALUControl_o=001 in state 6; the same fields with op 0010011 give 000; funct3 110 gives 011.
- beq: zero_i=1 → PCWrite_o=1 in state 9; zero_i=0 → PCWrite_o=0 in state 9. Both cases return to state 0 after 3 cycles.
- jal → states 0,1,10,8 with PCWrite_o=1 in state 10. lui → states 0,1,11 with ResultSrc_o=11 and ImmSrc_o=100. Op 1111111 → states 0,1,0 with illegal_o pulse in state 1 and no writes.
